// File: rtl/pair_mem_pkg.sv
// Shared constants and state encoding for the even/odd pair buffer writer and reader.
// Both sides import this so their address maps cannot drift apart.
package pair_mem_pkg;

    localparam int DEFAULT_ADDR_W    = 14;
    localparam int DEFAULT_DATA_W    = 16;
    localparam int DEFAULT_BASE_PAIR = 3072;
    localparam int DEFAULT_END_PAIR  = 3584;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pair_addr_counter.sv
// Pair index counter: loads to BASE_PAIR, increments, and flags the last pair of a sweep.
// The flag looks at the current index, so the counter reaches END_PAIR at most and never wraps.
module pair_addr_counter #(
    parameter int PAIR_W    = 13,
    parameter int BASE_PAIR = 3072,
    parameter int END_PAIR  = 3584
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    output logic [PAIR_W-1:0] pair,
    output logic              last
);

    // NOTE: asynchronous active-low reset sits in the sensitivity list; sequential state uses <= only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pair <= PAIR_W'(BASE_PAIR);
        end else if (load) begin
            pair <= PAIR_W'(BASE_PAIR);
        end else if (inc) begin
            pair <= pair + 1'b1;
        end
    end

    assign last = (pair == PAIR_W'(END_PAIR - 1));

endmodule

// File: rtl/pair_write_sequencer.sv
// Packs a valid/ready sample stream into even/odd pairs and writes each pair to a
// dual-port RAM in one cycle, sweeping pair indices BASE_PAIR..END_PAIR-1.
module pair_write_sequencer
    import pair_mem_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BASE_PAIR = DEFAULT_BASE_PAIR,
    parameter int END_PAIR  = DEFAULT_END_PAIR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              we_a,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] din_a,
    output logic              we_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] din_b,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] pair_count
);

    localparam int PAIR_W = ADDR_W - 1;

    state_t            state;
    logic [DATA_W-1:0] even_hold;
    logic [PAIR_W-1:0] pair;
    logic              last_pair;
    logic              accept;
    logic              load_pair;
    logic              inc_pair;

    // s_ready is registered and mirrors EVEN/ODD, so it is safe to use in the handshake.
    assign accept    = s_valid && s_ready;
    assign load_pair = start && ((state == IDLE) || (state == DONE));
    assign inc_pair  = accept && (state == ODD);

    pair_addr_counter #(
        .PAIR_W   (PAIR_W),
        .BASE_PAIR(BASE_PAIR),
        .END_PAIR (END_PAIR)
    ) u_pair_addr_counter (
        .clk  (clk),
        .reset(reset),
        .load (load_pair),
        .inc  (inc_pair),
        .pair (pair),
        .last (last_pair)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            even_hold  <= '0;
            s_ready    <= 1'b0;
            we_a       <= 1'b0;
            we_b       <= 1'b0;
            addr_a     <= {PAIR_W'(BASE_PAIR), 1'b0};
            addr_b     <= {PAIR_W'(BASE_PAIR), 1'b1};
            din_a      <= '0;
            din_b      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pair_count <= '0;
        end else begin
            // Strobes default low so each write is a single-cycle pulse.
            we_a <= 1'b0;
            we_b <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= EVEN;
                        s_ready    <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pair_count <= '0;
                        addr_a     <= {PAIR_W'(BASE_PAIR), 1'b0};
                        addr_b     <= {PAIR_W'(BASE_PAIR), 1'b1};
                    end
                end
                EVEN: begin
                    if (accept) begin
                        even_hold <= s_data;
                        state     <= ODD;
                    end
                end
                ODD: begin
                    if (accept) begin
                        din_a      <= even_hold;
                        din_b      <= s_data;
                        we_a       <= 1'b1;
                        we_b       <= 1'b1;
                        addr_a     <= {pair, 1'b0};
                        addr_b     <= {pair, 1'b1};
                        pair_count <= pair_count + 1'b1;
                        if (last_pair) begin
                            state   <= DONE;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state <= EVEN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pair_write_sequencer.sv
// Self-checking bench for pair_write_sequencer: vector table for the first pairs, randomized
// sweeps checked against an arithmetic model of the pair layout, and reset/start corner cases.
module tb_pair_write_sequencer;

    localparam int BASE_ADDR = 6144;
    localparam int N_SAMPLES = 1024;
    localparam int N_PAIRS   = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        we_a;
    logic [13:0] addr_a;
    logic [15:0] din_a;
    logic        we_b;
    logic [13:0] addr_b;
    logic [15:0] din_b;
    logic        busy;
    logic        done;
    logic [12:0] pair_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] samples [N_SAMPLES];
    logic [15:0] ram     [N_SAMPLES];

    typedef struct {
        logic        start;
        logic        valid;
        logic [15:0] data;
        logic        exp_ready;
        logic        exp_we;
        int          exp_addr_a;
        logic [15:0] exp_din_a;
        logic [15:0] exp_din_b;
        int          exp_count;
    } vec_t;

    vec_t vecs [7];

    pair_write_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .din_a     (din_a),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .din_b     (din_b),
        .busy      (busy),
        .done      (done),
        .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        s_valid = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Sweep model: sample k lands at word BASE_ADDR+k; odd k completes pair k/2 and
    // must be written exactly one cycle after its handshake.
    task automatic run_sweep(input int duty, input bit start_mid);
        int   k       = 0;
        int   cyc     = 0;
        int   strobes = 0;
        int   bad_ram = 0;
        int   oob     = 0;
        int   p;
        int   idx;
        bit   pulsed  = 1'b0;
        logic acc;
        logic exp_we;
        for (int i = 0; i < N_SAMPLES; i++) ram[i] = 16'h0;
        while (k < N_SAMPLES && cyc < 20000) begin
            check("sweep_ready", 32'(s_ready), 32'd1);
            check("sweep_busy", 32'(busy), 32'd1);
            s_valid = ($urandom_range(99) < duty);
            s_data  = samples[k];
            if (start_mid && k == 3 && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            acc = s_valid && s_ready;
            tick();
            cyc++;
            start = 1'b0;
            if (we_a) begin
                strobes++;
                idx = int'(addr_a) - BASE_ADDR;
                if (idx >= 0 && idx < N_SAMPLES) ram[idx] = din_a; else oob++;
            end
            if (we_b) begin
                idx = int'(addr_b) - BASE_ADDR;
                if (idx >= 0 && idx < N_SAMPLES) ram[idx] = din_b; else oob++;
            end
            exp_we = acc && (k % 2 == 1);
            check("sweep_we_a", 32'(we_a), 32'(exp_we));
            check("sweep_we_b", 32'(we_b), 32'(exp_we));
            if (exp_we) begin
                p = k / 2;
                check("sweep_addr_a", 32'(addr_a), 32'(BASE_ADDR + 2 * p));
                check("sweep_addr_b", 32'(addr_b), 32'(BASE_ADDR + 2 * p + 1));
                check("sweep_din_a", 32'(din_a), 32'(samples[k-1]));
                check("sweep_din_b", 32'(din_b), 32'(samples[k]));
                check("sweep_pair_count", 32'(pair_count), 32'(p + 1));
                check("sweep_done", 32'(done), 32'(k == N_SAMPLES - 1));
            end
            if (acc) k++;
        end
        check("sweep_finished_in_budget", 32'(k), 32'(N_SAMPLES));
        check("sweep_strobe_count", 32'(strobes), 32'(N_PAIRS));
        check("sweep_out_of_range_writes", 32'(oob), 32'd0);
        for (int i = 0; i < N_SAMPLES; i++) if (ram[i] !== samples[i]) bad_ram++;
        check("sweep_ram_contents", 32'(bad_ram), 32'd0);
        // Samples offered after completion must be refused.
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 16'hDEAD;
            tick();
            check("post_ready", 32'(s_ready), 32'd0);
            check("post_we", 32'(we_a | we_b), 32'd0);
            check("post_done", 32'(done), 32'd1);
            check("post_busy", 32'(busy), 32'd0);
            check("post_pair_count", 32'(pair_count), 32'(N_PAIRS));
        end
        s_valid = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0;
        for (int i = 0; i < N_SAMPLES; i++) samples[i] = 16'($urandom);

        // start held high during reset must not arm a sweep
        start = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        start = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        for (int i = 0; i < 10; i++) tick();
        check("idle_ready", 32'(s_ready), 32'd0);
        check("idle_we", 32'(we_a | we_b), 32'd0);
        check("idle_addr_a", 32'(addr_a), 32'd6144);
        check("idle_addr_b", 32'(addr_b), 32'd6145);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_pair_count", 32'(pair_count), 32'd0);
        check("idle_din_a", 32'(din_a), 32'd0);

        // First pairs, including a start pulse while busy (row 4)
        vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 6144, 16'h0000, 16'h0000, 0};
        vecs[1] = '{1'b0, 1'b1, 16'hA000, 1'b1, 1'b0, 6144, 16'h0000, 16'h0000, 0};
        vecs[2] = '{1'b0, 1'b1, 16'hA001, 1'b1, 1'b1, 6144, 16'hA000, 16'hA001, 1};
        vecs[3] = '{1'b0, 1'b0, 16'h5555, 1'b1, 1'b0, 6144, 16'hA000, 16'hA001, 1};
        vecs[4] = '{1'b1, 1'b0, 16'h5555, 1'b1, 1'b0, 6144, 16'hA000, 16'hA001, 1};
        vecs[5] = '{1'b0, 1'b1, 16'hA002, 1'b1, 1'b0, 6144, 16'hA000, 16'hA001, 1};
        vecs[6] = '{1'b0, 1'b1, 16'hA003, 1'b1, 1'b1, 6146, 16'hA002, 16'hA003, 2};
        for (int i = 0; i < 7; i++) begin
            start   = vecs[i].start;
            s_valid = vecs[i].valid;
            s_data  = vecs[i].data;
            tick();
            start   = 1'b0;
            check($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_we_a", i), 32'(we_a), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_we_b", i), 32'(we_b), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_addr_a", i), 32'(addr_a), 32'(vecs[i].exp_addr_a));
            check($sformatf("vec%0d_addr_b", i), 32'(addr_b), 32'(vecs[i].exp_addr_a + 1));
            check($sformatf("vec%0d_din_a", i), 32'(din_a), 32'(vecs[i].exp_din_a));
            check($sformatf("vec%0d_din_b", i), 32'(din_b), 32'(vecs[i].exp_din_b));
            check($sformatf("vec%0d_pair_count", i), 32'(pair_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
        end

        // Fresh full sweep with continuous valid
        s_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        do_start();
        run_sweep(100, 1'b0);

        // Restart from DONE, then a gappy sweep with a start pulse after 3 samples
        do_start();
        check("restart_done", 32'(done), 32'd0);
        check("restart_addr_a", 32'(addr_a), 32'd6144);
        check("restart_pair_count", 32'(pair_count), 32'd0);
        run_sweep(50, 1'b1);

        // Reset while a half pair is held
        do_start();
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        tick();
        s_data  = 16'hBEE0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(we_a | we_b), 32'd0);
        check("rst_addr_a", 32'(addr_a), 32'd6144);
        check("rst_din_a", 32'(din_a), 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_idle_we", 32'(we_a | we_b), 32'd0);
            check("rst_idle_ready", 32'(s_ready), 32'd0);
        end
        do_start();
        s_valid = 1'b1;
        s_data  = 16'hC0DE;
        tick();
        check("after_rst_even_we", 32'(we_a), 32'd0);
        s_data  = 16'hC0DF;
        tick();
        s_valid = 1'b0;
        check("after_rst_we_a", 32'(we_a), 32'd1);
        check("after_rst_we_b", 32'(we_b), 32'd1);
        check("after_rst_addr_a", 32'(addr_a), 32'd6144);
        check("after_rst_addr_b", 32'(addr_b), 32'd6145);
        check("after_rst_din_a", 32'(din_a), 32'hC0DE);
        check("after_rst_din_b", 32'(din_b), 32'hC0DF);
        check("after_rst_pair_count", 32'(pair_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
